execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 146 ++++++++++++++
 tb/tb_execute_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// EX stage: ALU plus EX/MEM pipeline register; 1-cycle latency, Stall holds and Flush/!Valid_i load a bubble.
// Optional ALU_OVERFLOW_EN adds a registered signed-overflow flag that also cancels RegWrite.
module execute_stage #(
   parameter int N_BITS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        ALUOperation,
   input  logic [N_BITS-1:0] ReadData1,
   input  logic [N_BITS-1:0] ReadData2,
   input  logic [N_BITS-1:0] Immediate,
   input  logic              ALUSrc,
   input  logic [4:0]        Shamt,
   input  logic [4:0]        WriteRegister_i,
   input  logic              RegWrite_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic              MemtoReg_i,
   input  logic              Valid_i,
   input  logic              Stall,
   input  logic              Flush,
   output logic [N_BITS-1:0] ALUResult_o,
   output logic              Zero_o,
   output logic [N_BITS-1:0] WriteData_o,
   output logic [4:0]        WriteRegister_o,
   output logic              RegWrite_o,
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic              MemtoReg_o,
`ifdef ALU_OVERFLOW_EN
   output logic              Overflow_o,
`endif
   output logic              Valid_o
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_NOR = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_LUI = 4'b0111;

   typedef struct packed {
      logic [N_BITS-1:0] result;
      logic [N_BITS-1:0] wdata;
      logic [4:0]        wreg;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
`ifdef ALU_OVERFLOW_EN
      logic              overflow;
`endif
      logic              valid;
   } exmem_t;

   localparam exmem_t C_BUBBLE = '0;

   logic [N_BITS-1:0] w_op_a;
   logic [N_BITS-1:0] w_op_b;
   logic [N_BITS-1:0] w_sum;
   logic [N_BITS-1:0] w_diff;
   logic [N_BITS-1:0] w_result;
   logic              w_overflow;
   exmem_t            w_next;
   exmem_t            r_exmem;

   assign w_op_a = ReadData1;
   assign w_op_b = ALUSrc ? Immediate : ReadData2;
   assign w_sum  = w_op_a + w_op_b;
   assign w_diff = w_op_a - w_op_b;

   always_comb begin
      w_result = '0;
      case (ALUOperation)
         OP_AND:  w_result = w_op_a & w_op_b;
         OP_OR:   w_result = w_op_a | w_op_b;
         OP_NOR:  w_result = ~(w_op_a | w_op_b);
         OP_ADD:  w_result = w_sum;
         OP_SUB:  w_result = w_diff;
         OP_SLL:  w_result = w_op_b << Shamt;
         OP_SRL:  w_result = w_op_b >> Shamt;
         OP_LUI:  w_result = w_op_b << 16;
         default: w_result = '0;
      endcase
   end

   // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
   always_comb begin
      w_overflow = 1'b0;
      case (ALUOperation)
         OP_ADD:  w_overflow = (w_op_a[N_BITS-1] == w_op_b[N_BITS-1]) &&
                               (w_sum[N_BITS-1] != w_op_a[N_BITS-1]);
         OP_SUB:  w_overflow = (w_op_a[N_BITS-1] != w_op_b[N_BITS-1]) &&
                               (w_diff[N_BITS-1] != w_op_a[N_BITS-1]);
         default: w_overflow = 1'b0;
      endcase
   end

   always_comb begin
      w_next            = C_BUBBLE;
      w_next.result     = w_result;
      w_next.wdata      = ReadData2;
      w_next.wreg       = WriteRegister_i;
      w_next.mem_read   = MemRead_i;
      w_next.mem_write  = MemWrite_i;
      w_next.mem_to_reg = MemtoReg_i;
      w_next.valid      = 1'b1;
`ifdef ALU_OVERFLOW_EN
      w_next.overflow   = w_overflow;
      w_next.reg_write  = RegWrite_i & ~w_overflow;
`else
      w_next.reg_write  = RegWrite_i;
`endif
   end

   // Flush beats Stall; an empty slot only becomes a bubble when the register is free to move.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_exmem <= C_BUBBLE;
      end else if (Flush) begin
         r_exmem <= C_BUBBLE;
      end else if (!Stall) begin
         r_exmem <= Valid_i ? w_next : C_BUBBLE;
      end
   end

   assign ALUResult_o     = r_exmem.result;
   assign Zero_o          = (r_exmem.result == '0);
   assign WriteData_o     = r_exmem.wdata;
   assign WriteRegister_o = r_exmem.wreg;
   assign RegWrite_o      = r_exmem.reg_write;
   assign MemRead_o       = r_exmem.mem_read;
   assign MemWrite_o      = r_exmem.mem_write;
   assign MemtoReg_o      = r_exmem.mem_to_reg;
   assign Valid_o         = r_exmem.valid;
`ifdef ALU_OVERFLOW_EN
   assign Overflow_o      = r_exmem.overflow;
`else
   logic w_unused;
   assign w_unused = w_overflow;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: table of vectors through a scoreboard queue, plus stall/flush and reset sequences.
module tb_execute_stage;

   logic        clk;
   logic        reset;
   logic [3:0]  ALUOperation;
   logic [31:0] ReadData1, ReadData2, Immediate;
   logic        ALUSrc;
   logic [4:0]  Shamt, WriteRegister_i;
   logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
   logic        Valid_i, Stall, Flush;
   logic [31:0] ALUResult_o, WriteData_o;
   logic        Zero_o;
   logic [4:0]  WriteRegister_o;
   logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, Valid_o;
`ifdef ALU_OVERFLOW_EN
   logic        Overflow_o;
`endif

   execute_stage #(.N_BITS(32)) dut (
      .clk(clk), .reset(reset), .ALUOperation(ALUOperation),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .Immediate(Immediate),
      .ALUSrc(ALUSrc), .Shamt(Shamt), .WriteRegister_i(WriteRegister_i),
      .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .MemtoReg_i(MemtoReg_i), .Valid_i(Valid_i), .Stall(Stall), .Flush(Flush),
      .ALUResult_o(ALUResult_o), .Zero_o(Zero_o), .WriteData_o(WriteData_o),
      .WriteRegister_o(WriteRegister_o), .RegWrite_o(RegWrite_o),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
`ifdef ALU_OVERFLOW_EN
      .Overflow_o(Overflow_o),
`endif
      .Valid_o(Valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic        alusrc;
      logic [4:0]  shamt;
      logic [4:0]  wr;
      logic [3:0]  ctl;   // {RegWrite, MemRead, MemWrite, MemtoReg}
      logic        vld;
      logic [31:0] res;   // hand-derived ALU result
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic [3:0]  ctl;
      logic        vld;
      logic        ovf;
   } exp_t;

   localparam int NV = 14;
   vec_t vecs [NV];
   exp_t sb [$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic exp_t expect_of(input vec_t v);
      exp_t e;
      if (!v.vld) begin
         e = '{res: 32'd0, zero: 1'b1, wd: 32'd0, wr: 5'd0, ctl: 4'd0, vld: 1'b0, ovf: 1'b0};
      end else begin
         e.res  = v.res;
         e.zero = (v.res == 32'd0);
         e.wd   = v.rd2;
         e.wr   = v.wr;
         e.ctl  = v.ctl;
         e.vld  = 1'b1;
         e.ovf  = v.ovf;
`ifdef ALU_OVERFLOW_EN
         if (v.ovf) e.ctl[3] = 1'b0;
`endif
      end
      return e;
   endfunction

   task automatic drive(input vec_t v);
      ALUOperation    = v.op;
      ReadData1       = v.a;
      ReadData2       = v.rd2;
      Immediate       = v.imm;
      ALUSrc          = v.alusrc;
      Shamt           = v.shamt;
      WriteRegister_i = v.wr;
      {RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i} = v.ctl;
      Valid_i         = v.vld;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".valid"},  {31'd0, Valid_o}, 32'd0);
      chk({tag, ".regwr"},  {31'd0, RegWrite_o}, 32'd0);
      chk({tag, ".ctl"},    {29'd0, MemRead_o, MemWrite_o, MemtoReg_o}, 32'd0);
      chk({tag, ".zero"},   {31'd0, Zero_o}, 32'd1);
      chk({tag, ".result"}, ALUResult_o, 32'd0);
      chk({tag, ".wdata"},  WriteData_o, 32'd0);
`ifdef ALU_OVERFLOW_EN
      chk({tag, ".ovf"},    {31'd0, Overflow_o}, 32'd0);
`endif
   endtask

   initial begin
      vec_t v;
      exp_t e;
      vecs[0]  = '{4'b0011, 32'd7,        32'd5,        32'd0,        1'b0, 5'd0,  5'd3,  4'b1000, 1'b1, 32'd12,       1'b0};
      vecs[1]  = '{4'b0100, 32'h1234,     32'h1234,     32'd0,        1'b0, 5'd0,  5'd4,  4'b1000, 1'b1, 32'd0,        1'b0};
      vecs[2]  = '{4'b0101, 32'h5555,     32'd1,        32'd0,        1'b0, 5'd31, 5'd5,  4'b1000, 1'b1, 32'h80000000, 1'b0};
      vecs[3]  = '{4'b0111, 32'h0,        32'hFFFF,     32'h0000ABCD, 1'b1, 5'd0,  5'd6,  4'b1000, 1'b1, 32'hABCD0000, 1'b0};
      vecs[4]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b0, 5'd0,  5'd7,  4'b0101, 1'b1, 32'hF000F000, 1'b0};
      vecs[5]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b0, 5'd0,  5'd8,  4'b0010, 1'b1, 32'hFFF0FFF0, 1'b0};
      vecs[6]  = '{4'b0010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0,        1'b0, 5'd0,  5'd9,  4'b1000, 1'b1, 32'h00000000, 1'b0};
      vecs[7]  = '{4'b0110, 32'h0,        32'h80000000, 32'd0,        1'b0, 5'd4,  5'd10, 4'b1000, 1'b1, 32'h08000000, 1'b0};
      vecs[8]  = '{4'b1001, 32'hFFFF,     32'hFFFF,     32'd0,        1'b0, 5'd3,  5'd11, 4'b1000, 1'b1, 32'd0,        1'b0};
      vecs[9]  = '{4'b1111, 32'h1,        32'h2,        32'd0,        1'b0, 5'd1,  5'd12, 4'b1000, 1'b1, 32'd0,        1'b0};
      vecs[10] = '{4'b0100, 32'd0,        32'd1,        32'd0,        1'b0, 5'd0,  5'd13, 4'b1000, 1'b1, 32'hFFFFFFFF, 1'b0};
      vecs[11] = '{4'b0011, 32'd3,        32'd4,        32'd0,        1'b0, 5'd0,  5'd14, 4'b1111, 1'b0, 32'd7,        1'b0};
      vecs[12] = '{4'b0011, 32'h20,       32'hDEAD,     32'h10,       1'b1, 5'd0,  5'd15, 4'b1001, 1'b1, 32'h30,       1'b0};
      vecs[13] = '{4'b0011, 32'h7FFFFFFF, 32'd1,        32'd0,        1'b0, 5'd0,  5'd16, 4'b1000, 1'b1, 32'h80000000, 1'b1};

      // Reset state, and reset overriding Stall with a valid instruction present.
      reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
      drive(vecs[0]);
      #1 chk_bubble("reset");
      Stall = 1'b1;
      @(posedge clk); #1 chk_bubble("reset_ovr");
      @(negedge clk); reset = 1'b0; Stall = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         sb.push_back(expect_of(vecs[i]));
         @(posedge clk); #1;
         if (sb.size() == 0) begin
            chk($sformatf("v%0d.sb_empty", i), 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d.result", i), ALUResult_o, e.res);
            chk($sformatf("v%0d.zero", i), {31'd0, Zero_o}, {31'd0, e.zero});
            chk($sformatf("v%0d.wdata", i), WriteData_o, e.wd);
            chk($sformatf("v%0d.wreg", i), {27'd0, WriteRegister_o}, {27'd0, e.wr});
            chk($sformatf("v%0d.ctl", i), {28'd0, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o},
                {28'd0, e.ctl});
            chk($sformatf("v%0d.valid", i), {31'd0, Valid_o}, {31'd0, e.vld});
`ifdef ALU_OVERFLOW_EN
            chk($sformatf("v%0d.ovf", i), {31'd0, Overflow_o}, {31'd0, e.ovf});
`endif
         end
      end

      // Stall holds a loaded SUB while inputs keep changing, including an empty slot.
      @(negedge clk);
      v = '{4'b0100, 32'd10, 32'd3, 32'd0, 1'b0, 5'd0, 5'd7, 4'b1000, 1'b1, 32'd7, 1'b0};
      drive(v);
      @(posedge clk); #1 chk("stall.load", ALUResult_o, 32'd7);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         Stall = 1'b1;
         ALUOperation = 4'b0001; ReadData1 = $urandom; ReadData2 = 32'hCAFE0000 + k;
         WriteRegister_i = 5'd20 + 5'(k); Valid_i = (k != 1); RegWrite_i = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("stall%0d.result", k), ALUResult_o, 32'd7);
         chk($sformatf("stall%0d.valid", k), {31'd0, Valid_o}, 32'd1);
         chk($sformatf("stall%0d.wreg", k), {27'd0, WriteRegister_o}, 32'd7);
         chk($sformatf("stall%0d.wdata", k), WriteData_o, 32'd3);
         chk($sformatf("stall%0d.regwr", k), {31'd0, RegWrite_o}, 32'd1);
      end
      @(negedge clk);
      Flush = 1'b1; Valid_i = 1'b1; RegWrite_i = 1'b1;
      @(posedge clk); #1 chk_bubble("flush_stall");
      @(negedge clk); Flush = 1'b0; Stall = 1'b0;

      // Asynchronous reset mid-cycle, then normal load on the first edge after release.
      v = '{4'b0011, 32'd2, 32'd2, 32'd0, 1'b0, 5'd0, 5'd9, 4'b1000, 1'b1, 32'd4, 1'b0};
      drive(v);
      @(posedge clk); #1 chk("rst.pre_result", ALUResult_o, 32'd4);
      #2 reset = 1'b1;
      #1 chk_bubble("rst_async");
      @(negedge clk);
      reset = 1'b0;
      v = '{4'b0011, 32'd9, 32'd1, 32'd0, 1'b0, 5'd0, 5'd2, 4'b1000, 1'b1, 32'd10, 1'b0};
      drive(v);
      @(posedge clk); #1;
      chk("rst.post_result", ALUResult_o, 32'd10);
      chk("rst.post_valid", {31'd0, Valid_o}, 32'd1);
      chk("rst.post_regwr", {31'd0, RegWrite_o}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
